// File: rtl/plm_pkg.sv
// rtl/plm_pkg.sv - shared state type and widths for period_lock_monitor
package plm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } plm_state_e;

    localparam int CNT_W  = 8;
    localparam int LOSS_W = 16;

endpackage

// File: rtl/plm_watchdog.sv
// rtl/plm_watchdog.sv - saturating cycles-since-sample counter with expiry strobe
module plm_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Strobes on the edge where the count reaches its limit; a clear wins.
    assign expire = !clr && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/period_lock_monitor.sv
// rtl/period_lock_monitor.sv - lock detector over period samples; PLM_STATS_EN adds loss/deviation stats
module period_lock_monitor
    import plm_pkg::*;
#(
    parameter int W           = 32,
    parameter int TOL         = 50,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_MISS = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         RST_N,
    input  logic         period_vld,
    input  logic [W-1:0] period_in,
    output logic         locked,
    output logic [1:0]   lock_state,
    output logic [W-1:0] ref_period,
    output logic         lock_lost,
    output logic         timeout
`ifdef PLM_STATS_EN
    ,
    output logic [LOSS_W-1:0] lock_loss_cnt,
    output logic [W-1:0]      max_dev
`endif
);

    localparam logic [CNT_W-1:0] LOCK_CNT_C    = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_MISS_C = CNT_W'(UNLOCK_MISS);
    localparam logic [W:0]       TOL_C         = (W + 1)'(TOL);

    plm_state_e       state_q, state_d;
    logic [W-1:0]     ref_q, ref_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             lock_lost_q, lock_lost_d;
    logic             timeout_q, timeout_d;
    logic             drop;
    logic             wd_expire;
    logic [W:0]       dev;
    logic             in_tol;

    plm_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (RST_N),
        .clr   (period_vld),
        .expire(wd_expire)
    );

    assign dev    = (period_in >= ref_q) ? ({1'b0, period_in} - {1'b0, ref_q})
                                         : ({1'b0, ref_q} - {1'b0, period_in});
    assign in_tol = (dev <= TOL_C);

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        stable_cnt_d = stable_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        locked_d     = locked_q;
        lock_lost_d  = 1'b0;
        timeout_d    = 1'b0;
        drop         = 1'b0;

        if (period_vld) begin
            if (period_in == '0) begin
                drop = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        ref_d        = period_in;
                        stable_cnt_d = '0;
                        state_d      = ACQUIRE;
                    end
                    ACQUIRE: begin
                        ref_d = period_in;
                        if (in_tol) begin
                            stable_cnt_d = stable_cnt_q + CNT_W'(1);
                            if (stable_cnt_d == LOCK_CNT_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            stable_cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (in_tol) begin
                            ref_d      = period_in;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = CNT_W'(1);
                            if (UNLOCK_MISS > 1) begin
                                state_d = HOLD;
                            end else begin
                                drop = 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        // Reference stays frozen at the last good sample until recovery.
                        if (in_tol) begin
                            ref_d      = period_in;
                            miss_cnt_d = '0;
                            state_d    = LOCKED;
                        end else begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                            if (miss_cnt_d == UNLOCK_MISS_C) begin
                                drop = 1'b1;
                            end
                        end
                    end
                    default: drop = 1'b1;
                endcase
            end
        end else if (wd_expire && (state_q != IDLE)) begin
            timeout_d = 1'b1;
            drop      = 1'b1;
        end

        if (drop) begin
            state_d      = IDLE;
            ref_d        = '0;
            stable_cnt_d = '0;
            miss_cnt_d   = '0;
            locked_d     = 1'b0;
            lock_lost_d  = (state_q == LOCKED) || (state_q == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            stable_cnt_q <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            stable_cnt_q <= stable_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            timeout_q    <= timeout_d;
        end
    end

    assign locked     = locked_q;
    assign lock_state = state_q;
    assign ref_period = ref_q;
    assign lock_lost  = lock_lost_q;
    assign timeout    = timeout_q;

`ifdef PLM_STATS_EN
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [W-1:0]      max_dev_q, max_dev_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        max_dev_d  = max_dev_q;
        if (lock_lost_d && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
        // dev never exceeds W bits since both operands are W-bit unsigned.
        if (period_vld && ((state_q == LOCKED) || (state_q == HOLD)) && (dev[W-1:0] > max_dev_q)) begin
            max_dev_d = dev[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            loss_cnt_q <= '0;
            max_dev_q  <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
            max_dev_q  <= max_dev_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
    assign max_dev       = max_dev_q;
`endif

endmodule

// File: doc/period_lock_monitor.md
Name: period_lock_monitor

Overview:
- Downstream consumer of the period measurement stage in the PLL simulation models; takes successive period_length_1000 samples and decides whether the measured clock is stable.
- Drives the lock indication used by the PLLE2_BASE model (LOCKED output).
- Tracks a reference period, counts consecutive in-tolerance samples to acquire lock, tolerates brief excursions, and drops lock on sustained error, zero period (reset/powerdown) or missing samples.

Parameters:
- W, 32, width of the period value (matches period_length_1000).
- TOL, 50, maximum absolute deviation (same units as period_in) that still counts as in-tolerance.
- LOCK_CNT, 8, consecutive in-tolerance samples after seeding required to lock; legal range 1..255.
- UNLOCK_MISS, 3, consecutive out-of-tolerance samples while locked before lock is dropped; legal range 1..255.
- TIMEOUT_CYC, 1024, clk cycles without period_vld before lock is dropped; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- RST_N  in  1  synchronous, active-low reset.
- period_vld  in  1  one-cycle strobe; period_in holds a new measurement.
- period_in  in  W  measured period, units x1000; 0 means no clock / powerdown.
- locked  out  1  registered lock indication.
- lock_state  out  2  current FSM state encoding.
- ref_period  out  W  current reference period.
- lock_lost  out  1  one-cycle pulse when locked falls.
- timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (RST_N=0 at a clk edge): state IDLE, locked=0, ref_period=0, stable_cnt=0, miss_cnt=0, wd_cnt=0, lock_lost=0, timeout=0. Reset mid-operation aborts any state the same edge; no pulse is emitted.
- Deviation: dev = |period_in - ref_period|, computed at W+1 bits, no wrap. in_tol = (dev <= TOL).
- States: IDLE=0, ACQUIRE=1, LOCKED=2, HOLD=3.
- IDLE: on vld with period_in != 0: ref<=period_in, stable_cnt<=0, go to ACQUIRE.
- ACQUIRE, on vld:
  - in_tol: stable_cnt++, ref<=period_in. When the incremented count equals LOCK_CNT, go to LOCKED; locked=1 from the next cycle.
  - Not in_tol: ref<=period_in (re-seed), stable_cnt<=0.
- LOCKED, on vld:
  - in_tol: ref<=period_in, miss_cnt<=0.
  - Not in_tol: miss_cnt<=1, ref frozen. Go to HOLD if UNLOCK_MISS>1, else go directly to IDLE.
- HOLD (locked stays 1), on vld:
  - in_tol: go to LOCKED, miss_cnt<=0, ref<=period_in.
  - Not in_tol: miss_cnt++. When it reaches UNLOCK_MISS, go to IDLE.
- Any state, vld with period_in==0: go to IDLE next edge; zero is never seeded as reference.
- Watchdog: wd_cnt clears on vld and otherwise increments, saturating at TIMEOUT_CYC. When it reaches TIMEOUT_CYC while the state is not IDLE: timeout pulse, go to IDLE. The watchdog does not fire in IDLE.
- Same-cycle vld and watchdog expiry: vld wins, and the watchdog is cleared.
- Every transition from LOCKED/HOLD to IDLE: locked<=0 and a lock_lost pulse, both in the same registered cycle.
- On any entry to IDLE: stable_cnt, miss_cnt and ref_period are cleared.
- Latency: all outputs are registered, one clk after the causing vld/event. No combinational input-to-output path.
- Counters are 8 bits and cannot overflow within the legal parameter range.

Optional Feature:
- Macro PLM_STATS_EN.
- Defined: adds outputs lock_loss_cnt[15:0] and max_dev[W-1:0].
  - lock_loss_cnt increments on each lock_lost and saturates at 16'hFFFF.
  - max_dev holds the largest dev seen on vld while in LOCKED/HOLD.
  - Both are cleared only by reset.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package plm_pkg:
  - state typedef (IDLE/ACQUIRE/LOCKED/HOLD, 2 bits).
  - counter width constant CNT_W=8.
  - stats width constant LOSS_W=16.
- Sub-module plm_watchdog: saturating cycle counter with clear and expiry pulse; parameter TIMEOUT_CYC.
- FSM, deviation compare and stats stay in period_lock_monitor.

Test Plan:
- Acquire: after reset, 9 vld with period_in=10000 every 100 cycles -> locked=1 one cycle after the 9th vld (seed + 8); ref_period=10000; lock_state=2.
- Drift within tolerance: while locked, samples 10040, 10080, 10120 -> stays locked; ref_period tracks to 10120.
- Excursion then recovery: while locked, 2 samples of 11000 then 10000 -> lock_state goes 3 then 2; locked stays 1; no lock_lost.
- Sustained error: while locked, 3 samples of 11000 -> on the 3rd, locked=0, one lock_lost pulse, lock_state=0, ref_period=0.
- Clock stop: lock acquired, then no vld for 1024 cycles -> timeout and lock_lost pulse in the same cycle; locked=0. A vld arriving on the expiry cycle keeps lock instead.
- Zero/reset: vld with period_in=0 while locked -> IDLE with lock_lost pulse. With PLM_STATS_EN, after three losses lock_loss_cnt=3; RST_N=0 mid-ACQUIRE clears all outputs with no pulse.
